// File: rtl/gpo_cmd_master_if.sv
// Request/response handshake plus GPO/GPI command bus between a requester, gpo_cmd_master and the register file.
// The master modport is the command initiator; the slave modport is the requester/register-file side.
interface gpo_cmd_master_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [7:0]  i_req_cmd;
    logic [22:0] i_req_data;
    logic        i_req_wide;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_data;
    logic [31:0] o_gpo;
    logic [31:0] i_gpi;
    logic        o_busy;

    modport master (
        input  i_req_valid, i_req_cmd, i_req_data, i_req_wide, i_rsp_ready, i_gpi,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_gpo, o_busy
    );

    modport slave (
        output i_req_valid, i_req_cmd, i_req_data, i_req_wide, i_rsp_ready, i_gpi,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_gpo, o_busy
    );
endinterface

// File: rtl/gpo_cmd_master.sv
// GPO command initiator: turns a request into setup/strobe phases on o_gpo, optional high-word fetch, one 64-bit response.
// Latency S+W+1 cycles narrow, 2(S+W)+1 wide; a stalled response holds data and blocks new requests.
module gpo_cmd_master #(
    parameter int          SETUP_CYC = 2,
    parameter int          WAIT_CYC  = 4,
    parameter logic [7:0]  HIGH_CMD  = 8'd11
) (
    input  logic              clk,
    input  logic              i_rst_n,
    gpo_cmd_master_if.master  bus
);

    localparam int MAX_CYC = (SETUP_CYC > WAIT_CYC) ? SETUP_CYC : WAIT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYC - 1);

    typedef struct packed {
        logic [7:0]  cmd;
        logic        en;
        logic [22:0] data;
    } gpo_word_t;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, SETUP_H, STROBE_H, RESP} state_t;

    state_t         state_q, state_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;
    logic [7:0]     cmd_q, cmd_nxt;
    logic [22:0]    data_q, data_nxt;
    logic           wide_q, wide_nxt;
    logic [31:0]    lo_q, lo_nxt;
    gpo_word_t      gpo_q, gpo_nxt;
    logic           req_rdy_q, req_rdy_nxt;
    logic           rsp_vld_q, rsp_vld_nxt;
    logic [63:0]    rsp_dat_q, rsp_dat_nxt;
    logic           busy_q, busy_nxt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            wide_q    <= 1'b0;
            lo_q      <= '0;
            gpo_q     <= '0;
            req_rdy_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            cmd_q     <= cmd_nxt;
            data_q    <= data_nxt;
            wide_q    <= wide_nxt;
            lo_q      <= lo_nxt;
            gpo_q     <= gpo_nxt;
            req_rdy_q <= req_rdy_nxt;
            rsp_vld_q <= rsp_vld_nxt;
            rsp_dat_q <= rsp_dat_nxt;
            busy_q    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        cmd_nxt     = cmd_q;
        data_nxt    = data_q;
        wide_nxt    = wide_q;
        lo_nxt      = lo_q;
        rsp_dat_nxt = rsp_dat_q;
        // Outside a strobe the last word is held with enable low.
        gpo_nxt     = gpo_q;
        gpo_nxt.en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req_valid && req_rdy_q) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                    cmd_nxt   = bus.i_req_cmd;
                    data_nxt  = bus.i_req_data;
                    wide_nxt  = bus.i_req_wide;
                    gpo_nxt   = {bus.i_req_cmd, 1'b0, bus.i_req_data};
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = WAIT_LD;
                    gpo_nxt   = {cmd_q, 1'b1, data_q};
                end else begin
                    cnt_nxt   = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (wide_q) begin
                        state_nxt = SETUP_H;
                        cnt_nxt   = SETUP_LD;
                        lo_nxt    = bus.i_gpi;
                        gpo_nxt   = {HIGH_CMD, 1'b0, 23'b0};
                    end else begin
                        state_nxt   = RESP;
                        rsp_dat_nxt = {32'b0, bus.i_gpi};
                    end
                end else begin
                    cnt_nxt    = cnt_q - CW'(1);
                    gpo_nxt.en = 1'b1;
                end
            end
            SETUP_H: begin
                if (cnt_q == '0) begin
                    state_nxt = STROBE_H;
                    cnt_nxt   = WAIT_LD;
                    gpo_nxt   = {HIGH_CMD, 1'b1, 23'b0};
                end else begin
                    cnt_nxt   = cnt_q - CW'(1);
                end
            end
            STROBE_H: begin
                if (cnt_q == '0) begin
                    state_nxt   = RESP;
                    rsp_dat_nxt = {bus.i_gpi, lo_q};
                end else begin
                    cnt_nxt    = cnt_q - CW'(1);
                    gpo_nxt.en = 1'b1;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the state being entered.
        req_rdy_nxt = (state_nxt == IDLE);
        rsp_vld_nxt = (state_nxt == RESP);
        busy_nxt    = (state_nxt != IDLE);
    end

    assign bus.o_gpo       = gpo_q;
    assign bus.o_req_ready = req_rdy_q;
    assign bus.o_rsp_valid = rsp_vld_q;
    assign bus.o_rsp_data  = rsp_dat_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_gpo_cmd_master.sv
// Directed bench for gpo_cmd_master with a register-file receiver model (edge detect + registered GPI).
// Defaults S=2, W=4: narrow response at cycle 7, wide at cycle 13.
module tb_gpo_cmd_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gpo_cmd_master_if bus ();

    gpo_cmd_master #(
        .SETUP_CYC (2),
        .WAIT_CYC  (4),
        .HIGH_CMD  (8'd11)
    ) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] lo_val = 32'h0;
    logic [31:0] hi_val = 32'h0;

    // Receiver model: registered rising-edge detect, then GPI loaded the following edge.
    logic       en_d     = 1'b0;
    logic       pend     = 1'b0;
    logic [7:0] pend_cmd = 8'h0;
    int         rises    = 0;
    int         bad_gap  = 0;
    int         low_run  = 100;

    always @(posedge clk) begin
        en_d     <= bus.o_gpo[23];
        pend     <= bus.o_gpo[23] & ~en_d;
        pend_cmd <= bus.o_gpo[31:24];
        if (!rst_n)
            bus.i_gpi <= 32'h0;
        else if (pend)
            bus.i_gpi <= (pend_cmd == 8'd11) ? hi_val : lo_val;
        if (bus.o_gpo[23]) begin
            low_run <= 0;
            if (!en_d) begin
                rises <= rises + 1;
                if (low_run < 2) bad_gap <= bad_gap + 1;
            end
        end else begin
            low_run <= low_run + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc, resp, cyc, first, r0, b0, n;
        logic [31:0] exp_gpo;

        rst_n           = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_cmd   = 8'h33;
        bus.i_req_data  = 23'h0;
        bus.i_req_wide  = 1'b0;
        bus.i_rsp_ready = 1'b0;

        // Reset with a request pending
        repeat (3) tick();
        check("rst_gpo",       64'(bus.o_gpo),       64'h0);
        check("rst_req_ready", 64'(bus.o_req_ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
        check("rst_rsp_data",  bus.o_rsp_data,       64'h0);
        check("rst_busy",      64'(bus.o_busy),      64'h0);
        rst_n           = 1'b1;
        bus.i_req_valid = 1'b0;
        tick();
        check("rdy_after_rst", 64'(bus.o_req_ready), 64'h1);

        // Narrow cmd 1 data 1, response held off for 5 cycles
        lo_val          = 32'hCAFE_0001;
        bus.i_req_cmd   = 8'd1;
        bus.i_req_data  = 23'd1;
        bus.i_req_wide  = 1'b0;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_req_cmd   = 8'hEE;
        bus.i_req_data  = 23'h7FFFFF;
        bus.i_req_wide  = 1'b1;
        check("nar_ready_c1", 64'(bus.o_req_ready), 64'h0);
        check("nar_busy_c1",  64'(bus.o_busy),      64'h1);
        for (int c = 1; c <= 6; c++) begin
            exp_gpo = (c <= 2) ? 32'h0100_0001 : 32'h0180_0001;
            check($sformatf("nar_gpo_c%0d", c), 64'(bus.o_gpo), 64'(exp_gpo));
            check($sformatf("nar_vld_c%0d", c), 64'(bus.o_rsp_valid), 64'h0);
            tick();
        end
        check("nar_gpo_c7", 64'(bus.o_gpo), 64'h0100_0001);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_vld_%0d", k),   64'(bus.o_rsp_valid), 64'h1);
            check($sformatf("bp_data_%0d", k),  bus.o_rsp_data,       64'h0000_0000_CAFE_0001);
            check($sformatf("bp_ready_%0d", k), 64'(bus.o_req_ready), 64'h0);
            check($sformatf("bp_en_%0d", k),    64'(bus.o_gpo[23]),   64'h0);
            if (k < 4) tick();
        end
        bus.i_rsp_ready = 1'b1;
        tick();
        check("bp_ready_after", 64'(bus.o_req_ready), 64'h1);
        check("bp_vld_after",   64'(bus.o_rsp_valid), 64'h0);
        check("bp_busy_after",  64'(bus.o_busy),      64'h0);

        // Wide read cmd 7
        lo_val          = 32'h89AB_CDEF;
        hi_val          = 32'h0123_4567;
        bus.i_req_cmd   = 8'd7;
        bus.i_req_data  = 23'h012345;
        bus.i_req_wide  = 1'b1;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_req_wide  = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 2)      exp_gpo = 32'h0701_2345;
            else if (c <= 6) exp_gpo = 32'h0781_2345;
            else if (c <= 8) exp_gpo = 32'h0B00_0000;
            else             exp_gpo = 32'h0B80_0000;
            check($sformatf("wide_gpo_c%0d", c), 64'(bus.o_gpo), 64'(exp_gpo));
            if (c == 12) check("wide_vld_c12", 64'(bus.o_rsp_valid), 64'h0);
            tick();
        end
        check("wide_vld_c13",  64'(bus.o_rsp_valid), 64'h1);
        check("wide_data_c13", bus.o_rsp_data,       64'h0123_4567_89AB_CDEF);
        tick();
        check("wide_ready_c14", 64'(bus.o_req_ready), 64'h1);

        // Back-to-back requests with valid held high
        r0              = rises;
        b0              = bad_gap;
        acc             = 0;
        resp            = 0;
        cyc             = 0;
        first           = 0;
        bus.i_req_cmd   = 8'd2;
        bus.i_req_data  = 23'h00ABC;
        bus.i_req_valid = 1'b1;
        while (resp < 4 && cyc < 200) begin
            if (bus.o_req_ready && bus.i_req_valid) begin
                acc++;
                if (acc == 1) first = cyc;
                if (acc == 2) check("b2b_spacing", 64'(cyc - first), 64'd8);
            end
            if (bus.o_rsp_valid) resp++;
            tick();
            cyc++;
            if (acc == 4) bus.i_req_valid = 1'b0;
        end
        check("b2b_in_budget", 64'(cyc < 200), 64'h1);
        check("b2b_accepts",   64'(acc),       64'd4);
        repeat (2) tick();
        check("b2b_rises",     64'(rises - r0),   64'd4);
        check("b2b_low_gap",   64'(bad_gap - b0), 64'd0);

        // Reset in the fourth STROBE cycle
        lo_val          = 32'h1111_2222;
        bus.i_req_cmd   = 8'd3;
        bus.i_req_data  = 23'd3;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        repeat (5) tick();
        check("mid_en_strobe4", 64'(bus.o_gpo[23]), 64'h1);
        rst_n = 1'b0;
        tick();
        check("mid_en_dropped", 64'(bus.o_gpo[23]),   64'h0);
        check("mid_no_rsp",     64'(bus.o_rsp_valid), 64'h0);
        check("mid_busy",       64'(bus.o_busy),      64'h0);
        rst_n = 1'b1;
        tick();
        check("mid_ready", 64'(bus.o_req_ready), 64'h1);
        check("mid_still_no_rsp", 64'(bus.o_rsp_valid), 64'h0);

        lo_val          = 32'h55AA_55AA;
        bus.i_req_cmd   = 8'd4;
        bus.i_req_data  = 23'd5;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        n = 1;
        while (!bus.o_rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("rec_latency", 64'(n), 64'd7);
        check("rec_data",    bus.o_rsp_data, 64'h0000_0000_55AA_55AA);
        tick();
        check("rec_ready",   64'(bus.o_req_ready), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
